// File: rtl/ivbus_port_bank_if.sv
// ---------------------------------------------------------------------------
// ivbus_port_bank_if
// S8x305 IV-bus signal bundle between the core (master) and an IV-bus
// peripheral such as ivbus_port_bank (slave). All data is active-low.
//   MCLK     core -> bank  end-of-instruction strobe (high in cycle 3)
//   LB, RB   core -> bank  left/right bank enables, active-low
//   SC       core -> bank  select-command (address) strobe
//   WC       core -> bank  write-command strobe
//   IV_out   core -> bank  8-bit output bus, active-low
//   IV_in    bank -> core  8-bit read data, active-low, 8'hFF when idle
//   IV_drive bank -> core  high while the bank drives IV_in
// ---------------------------------------------------------------------------
interface ivbus_port_bank_if;
  logic       MCLK;
  logic       LB;
  logic       RB;
  logic       SC;
  logic       WC;
  logic [7:0] IV_out;
  logic [7:0] IV_in;
  logic       IV_drive;

  modport master (
    output MCLK, LB, RB, SC, WC, IV_out,
    input  IV_in, IV_drive
  );

  modport slave (
    input  MCLK, LB, RB, SC, WC, IV_out,
    output IV_in, IV_drive
  );
endinterface

// File: rtl/ivbus_port_bank.sv
// ---------------------------------------------------------------------------
// ivbus_port_bank
// Bank of NPORTS addressable 8-bit I/O ports on the S8x305 IV bus. Each port
// has a data register (BASE_ADDR+2i), a direction register (BASE_ADDR+2i+1),
// a 2-flop input synchroniser and an input change flag; irq is the
// registered OR of all change flags.
// Ports:
//   x1       core clock, rising edge
//   reset    asynchronous, active-low
//   bus      IV-bus slave modport (MCLK/LB/RB/SC/WC/IV_out in, IV_in/IV_drive out)
//   pin_in   pad inputs, port i on [8i+7:8i], asynchronous to x1
//   pin_out  output data registers
//   pin_oe   direction registers, 1 = output
//   irq      OR of all port change flags (registered)
// ---------------------------------------------------------------------------
module ivbus_port_bank #(
  parameter int         NPORTS    = 4,
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter bit         BANK      = 1'b0
) (
  input  logic                  x1,
  input  logic                  reset,
  ivbus_port_bank_if.slave      bus,
  input  logic [8*NPORTS-1:0]   pin_in,
  output logic [8*NPORTS-1:0]   pin_out,
  output logic [8*NPORTS-1:0]   pin_oe,
  output logic                  irq
);

  // Claimed range in 9 bits so the upper bound may equal 9'h100.
  localparam logic [8:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [8:0] ADDR_HI = ADDR_LO + 9'(2 * NPORTS);

  logic       w_en;
  logic [7:0] w_bus_val;     // IV_out with the bus inversion removed
  logic       w_in_range;
  logic       w_addr_cycle;
  logic       w_write;
  logic       w_drive;
  logic [7:0] w_offset;
  logic [7:0] w_rd_data;
  logic [7:0] w_rd_term [NPORTS];
  logic [NPORTS-1:0] w_flags;

  logic [7:0] r_addr_q;
  logic       r_sel;
  logic       r_irq;

  assign w_en         = BANK ? ~bus.RB : ~bus.LB;
  assign w_bus_val    = ~bus.IV_out;
  assign w_in_range   = ({1'b0, w_bus_val} >= ADDR_LO) && ({1'b0, w_bus_val} < ADDR_HI);
  assign w_addr_cycle = bus.SC && w_en && bus.MCLK;
  // An address cycle on the same edge takes priority and drops the write.
  assign w_write      = bus.WC && w_en && bus.MCLK && r_sel && !bus.SC;
  assign w_drive      = w_en && r_sel && !bus.SC && !bus.WC;
  // Read/write decode works only from the registered address so the wide
  // read mux never sees a path from IV_out.
  assign w_offset     = r_addr_q - BASE_ADDR;

  always_ff @(posedge x1 or negedge reset) begin
    if (!reset) begin
      r_addr_q <= 8'h00;
      r_sel    <= 1'b0;
    end else if (w_addr_cycle) begin
      r_addr_q <= w_bus_val;
      r_sel    <= w_in_range;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      logic [7:0] r_out;
      logic [7:0] r_oe;
      logic [7:0] r_sync1;
      logic [7:0] r_sync2;
      logic [7:0] r_prev;
      logic       r_flag;
      logic       w_hit_data;
      logic       w_hit_dir;
      logic       w_set;
      logic       w_clr;
      logic [7:0] w_val;

      assign w_hit_data = (w_offset == 8'(2 * gi));
      assign w_hit_dir  = (w_offset == 8'(2 * gi + 1));
      // Only input-direction bits may raise the change flag.
      assign w_set      = |((r_sync2 ^ r_prev) & ~r_oe);
      // Cleared by the input-phase sample of this port's data register.
      assign w_clr      = w_drive && w_hit_data && !bus.MCLK;
      assign w_val      = (r_sync2 & ~r_oe) | (r_out & r_oe);

      always_ff @(posedge x1 or negedge reset) begin
        if (!reset) begin
          r_out   <= 8'h00;
          r_oe    <= 8'h00;
          r_sync1 <= 8'h00;
          r_sync2 <= 8'h00;
          r_prev  <= 8'h00;
          r_flag  <= 1'b0;
        end else begin
          if (w_write && w_hit_data) r_out <= w_bus_val;
          if (w_write && w_hit_dir)  r_oe  <= w_bus_val;
          r_sync1 <= pin_in[8*gi +: 8];
          r_sync2 <= r_sync1;
          r_prev  <= r_sync2;
          // Set has priority over a simultaneous clear.
          if (w_set)      r_flag <= 1'b1;
          else if (w_clr) r_flag <= 1'b0;
        end
      end

      assign w_rd_term[gi]      = ({8{w_hit_data}} & w_val) | ({8{w_hit_dir}} & r_oe);
      assign w_flags[gi]        = r_flag;
      assign pin_out[8*gi +: 8] = r_out;
      assign pin_oe[8*gi +: 8]  = r_oe;
    end
  endgenerate

  // One-hot AND-OR read mux; at most one term is non-zero.
  always_comb begin
    w_rd_data = 8'h00;
    for (int i = 0; i < NPORTS; i++) begin
      w_rd_data = w_rd_data | w_rd_term[i];
    end
  end

  always_ff @(posedge x1 or negedge reset) begin
    if (!reset) r_irq <= 1'b0;
    else        r_irq <= |w_flags;
  end

  assign irq          = r_irq;
  assign bus.IV_drive = w_drive;
  assign bus.IV_in    = w_drive ? ~w_rd_data : 8'hFF;

endmodule

// File: tb/tb_ivbus_port_bank.sv
module tb_ivbus_port_bank;

  logic        x1 = 1'b0;
  logic        reset;
  logic [31:0] pin_in;
  logic [31:0] pin_out;
  logic [31:0] pin_oe;
  logic        irq;

  ivbus_port_bank_if bus ();

  ivbus_port_bank #(
    .NPORTS   (4),
    .BASE_ADDR(8'h10),
    .BANK     (1'b0)
  ) dut (
    .x1     (x1),
    .reset  (reset),
    .bus    (bus),
    .pin_in (pin_in),
    .pin_out(pin_out),
    .pin_oe (pin_oe),
    .irq    (irq)
  );

  always #5 x1 = ~x1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state of the bank, updated from the stimulus only.
  logic [7:0] m_out [4];
  logic [7:0] m_oe  [4];
  logic [7:0] m_addr;
  logic       m_sel;
  logic [7:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic idle_bus();
    bus.MCLK   = 1'b0;
    bus.SC     = 1'b0;
    bus.WC     = 1'b0;
    bus.LB     = 1'b1;
    bus.RB     = 1'b1;
    bus.IV_out = 8'hFF;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge x1);
    #1;
  endtask

  function automatic logic [7:0] model_read();
    logic [7:0] off;
    logic [7:0] pin;
    int p;
    off = m_addr - 8'h10;
    p   = int'(off[2:1]);
    pin = pin_in[8*p +: 8];
    if (off[0]) return m_oe[p];
    return (pin & ~m_oe[p]) | (m_out[p] & m_oe[p]);
  endfunction

  // One instruction's output phase (MCLK high) on LB or RB.
  task automatic bus_cycle(input bit sc, input bit wc, input bit use_rb, input logic [7:0] val);
    logic [7:0] off;
    @(negedge x1);
    bus.LB     = use_rb;
    bus.RB     = !use_rb;
    bus.SC     = sc;
    bus.WC     = wc;
    bus.MCLK   = 1'b1;
    bus.IV_out = ~val;
    @(posedge x1);
    if (!use_rb) begin
      if (sc) begin
        m_addr = val;
        m_sel  = (val >= 8'h10) && (val < 8'h18);
      end else if (wc && m_sel) begin
        off = m_addr - 8'h10;
        if (off[0]) m_oe[int'(off[2:1])]  = val;
        else        m_out[int'(off[2:1])] = val;
      end
    end
    #1;
    idle_bus();
  endtask

  // Input phase (MCLK low) read on LB; expected value queued at drive time.
  task automatic read_cycle(input string tag);
    logic [7:0] exp_v;
    @(negedge x1);
    bus.LB   = 1'b0;
    bus.RB   = 1'b1;
    bus.MCLK = 1'b0;
    exp_v    = m_sel ? ~model_read() : 8'hFF;
    sb_q.push_back(exp_v);
    #1;
    check({tag, "_drv"}, 32'(bus.IV_drive), 32'(m_sel));
    check(tag, 32'(bus.IV_in), 32'(sb_q.pop_front()));
    @(posedge x1);
    #1;
    idle_bus();
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_out"}, pin_out, {m_out[3], m_out[2], m_out[1], m_out[0]});
    check({tag, "_oe"},  pin_oe,  {m_oe[3],  m_oe[2],  m_oe[1],  m_oe[0]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_out[i] = 8'h00;
      m_oe[i]  = 8'h00;
    end
    m_addr = 8'h00;
    m_sel  = 1'b0;
    pin_in = 32'h0;
    idle_bus();
    reset = 1'b0;
    bus.LB = 1'b0;
    wait_edges(3);
    check("rst_out", pin_out, 32'h0);
    check("rst_oe", pin_oe, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ivin", 32'(bus.IV_in), 32'hFF);
    check("rst_drv", 32'(bus.IV_drive), 32'h0);
    @(negedge x1);
    idle_bus();
    reset = 1'b1;

    // Reset asserted in the middle of a write cycle.
    bus_cycle(1, 0, 0, 8'h13);
    bus_cycle(0, 1, 0, 8'hFF);
    bus_cycle(1, 0, 0, 8'h12);
    check("pre_rst_oe", pin_oe, 32'h0000FF00);
    @(negedge x1);
    bus.LB = 1'b0; bus.WC = 1'b1; bus.MCLK = 1'b1; bus.IV_out = ~8'h55;
    #2;
    reset = 1'b0;
    @(posedge x1);
    #1;
    check("mid_rst_out", pin_out, 32'h0);
    check("mid_rst_oe", pin_oe, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_ivin", 32'(bus.IV_in), 32'hFF);
    check("mid_rst_drv", 32'(bus.IV_drive), 32'h0);
    @(negedge x1);
    reset = 1'b1;
    @(posedge x1);
    #1;
    idle_bus();
    for (int i = 0; i < 4; i++) begin
      m_out[i] = 8'h00;
      m_oe[i]  = 8'h00;
    end
    m_addr = 8'h00;
    m_sel  = 1'b0;
    wait_edges(2);
    check_regs("post_rst");

    // Write direction register of port 1 and read it back.
    bus_cycle(1, 0, 0, 8'h13);
    bus_cycle(0, 1, 0, 8'h0F);
    check("wr_oe_p1", 32'(pin_oe[15:8]), 32'h0F);
    read_cycle("rd_dir_p1");

    // Mixed direction read two edges after a pad change; the read's clear
    // lands on the same edge as the flag set, so the flag must survive.
    bus_cycle(1, 0, 0, 8'h12);
    bus_cycle(0, 1, 0, 8'h05);
    check("wr_out_p1", 32'(pin_out[15:8]), 32'h05);
    pin_in[15:8] = 8'hA0;
    wait_edges(2);
    read_cycle("rd_mixed");
    check("setclr_irq_early", 32'(irq), 32'h0);
    wait_edges(1);
    check("setclr_irq_kept", 32'(irq), 32'h1);
    read_cycle("rd_clear1");
    check("clr_irq_lag", 32'(irq), 32'h1);
    wait_edges(1);
    check("clr_irq_low", 32'(irq), 32'h0);

    // Change flag latency on input bit 15.
    pin_in[15] = 1'b0;
    wait_edges(3);
    check("flag_irq_e3", 32'(irq), 32'h0);
    wait_edges(1);
    check("flag_irq_e4", 32'(irq), 32'h1);
    read_cycle("rd_clear2");
    wait_edges(1);
    check("flag_irq_cleared", 32'(irq), 32'h0);

    // Toggling an output-direction pad must not raise a flag.
    pin_in[8] = 1'b1;
    wait_edges(5);
    check("oe_bit_no_irq", 32'(irq), 32'h0);

    // Out-of-range addresses above and below the bank.
    bus_cycle(1, 0, 0, 8'h18);
    read_cycle("rd_oor_hi");
    bus_cycle(0, 1, 0, 8'hAA);
    check_regs("oor_hi_wr");
    bus_cycle(1, 0, 0, 8'h0F);
    read_cycle("rd_oor_lo");

    // Traffic on RB is ignored by a BANK=0 instance.
    bus_cycle(1, 0, 1, 8'h12);
    read_cycle("rd_rb_sc");
    bus_cycle(1, 0, 0, 8'h10);
    bus_cycle(1, 0, 1, 8'h11);
    bus_cycle(0, 1, 1, 8'h77);
    check_regs("rb_wr");
    read_cycle("rd_after_rb");

    // SC and WC together: address moves, nothing is written.
    pin_in[23:16] = 8'h3C;
    wait_edges(3);
    bus_cycle(1, 1, 0, 8'h14);
    check_regs("scwc");
    read_cycle("rd_scwc_addr");

    // Last port of the bank.
    bus_cycle(1, 0, 0, 8'h17);
    bus_cycle(0, 1, 0, 8'hFF);
    bus_cycle(1, 0, 0, 8'h16);
    bus_cycle(0, 1, 0, 8'h42);
    check("wr_out_p3", 32'(pin_out[31:24]), 32'h42);
    read_cycle("rd_p3");
    check_regs("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
